// File: rtl/onewire_mch_master.sv
`timescale 1ns/1ps
// onewire_mch_master: multi-channel 1-wire bus master.
// Reset/presence, bit and byte slots with standard/overdrive timing.
module onewire_mch_master #(
  parameter int CHN   = 1,
  parameter int CDR_N = 50,
  parameter int CDR_O = 6,
  localparam int CW   = (CHN > 1) ? $clog2(CHN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_vld,
  output logic           req_rdy,
  input  logic [1:0]     req_cmd,
  input  logic [CW-1:0]  req_chn,
  input  logic           req_ovd,
  input  logic [7:0]     req_dat,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic [7:0]     rsp_dat,
  output logic           rsp_prs,
  output logic [CHN-1:0] owr_oe,
  input  logic [CHN-1:0] owr_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_RST_REC,
    S_BIT_LOW,
    S_BIT_WAIT,
    S_BIT_REC,
    S_RSP
  } state_t;

  localparam logic [15:0] DIV_N = 16'(CDR_N - 1);
  localparam logic [15:0] DIV_O = 16'(CDR_O - 1);

  state_t         r_st;
  logic [CHN-1:0] r_s1;
  logic [CHN-1:0] r_s2;
  logic [CHN-1:0] r_oe;
  logic [15:0]    r_pre;
  logic [15:0]    r_div;
  logic [9:0]     r_tick;
  logic [1:0]     r_cmd;
  logic [CW-1:0]  r_chn;
  logic [7:0]     r_dat;
  logic [2:0]     r_bit;
  logic           r_rdy;
  logic           r_vld;
  logic           r_prs;
  logic [7:0]     r_rsp;

  logic           w_last;
  logic           w_line;
  logic           w_wbit;
  logic           w_smp;
  logic           w_run;
  logic [9:0]     w_lend;

  // Out-of-range channels decode to an all-zero mask.
  function automatic logic [CHN-1:0] f_mask(input logic [CW-1:0] c);
    logic [CHN-1:0] m;
    m = '0;
    for (int i = 0; i < CHN; i++) m[i] = (c == CW'(i));
    return m;
  endfunction

  always_comb begin
    w_line = 1'b1;
    for (int i = 0; i < CHN; i++)
      if (r_chn == CW'(i)) w_line = r_s2[i];
  end

  assign w_last = (r_pre == r_div);
  assign w_wbit = r_dat[r_bit];
  assign w_lend = w_wbit ? 10'd5 : 10'd59;
  assign w_smp  = (r_pre == '0) && (r_tick == 10'd15);
  assign w_run  = (r_st != S_IDLE) && (r_st != S_RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_s1   <= '1;
      r_s2   <= '1;
      r_oe   <= '0;
      r_pre  <= '0;
      r_div  <= '0;
      r_tick <= '0;
      r_cmd  <= '0;
      r_chn  <= '0;
      r_dat  <= '0;
      r_bit  <= '0;
      r_rdy  <= 1'b0;
      r_vld  <= 1'b0;
      r_prs  <= 1'b0;
      r_rsp  <= '0;
    end else begin
      r_s1 <= owr_i;
      r_s2 <= r_s1;
      if (w_run) begin
        if (w_last) begin
          r_pre  <= '0;
          r_tick <= r_tick + 10'd1;
        end else begin
          r_pre <= r_pre + 16'd1;
        end
      end
      unique case (r_st)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (req_vld && r_rdy) begin
            r_rdy  <= 1'b0;
            r_cmd  <= req_cmd;
            r_chn  <= req_chn;
            r_dat  <= req_dat;
            r_div  <= req_ovd ? DIV_O : DIV_N;
            r_pre  <= '0;
            r_tick <= '0;
            r_bit  <= '0;
            r_rsp  <= '0;
            r_prs  <= 1'b0;
            unique case (req_cmd)
              2'b00: begin
                r_st <= S_RST_LOW;
                r_oe <= f_mask(req_chn);
              end
              2'b11: begin
                r_st  <= S_RSP;
                r_vld <= 1'b1;
              end
              default: begin
                r_st <= S_BIT_LOW;
                r_oe <= f_mask(req_chn);
              end
            endcase
          end
        end
        S_RST_LOW:
          if (w_last && r_tick == 10'd479) begin
            r_oe <= '0;
            r_st <= S_RST_WAIT;
          end
        S_RST_WAIT:
          if (r_pre == '0 && r_tick == 10'd550) begin
            r_prs <= ~w_line;
            r_st  <= S_RST_REC;
          end
        S_RST_REC:
          if (w_last && r_tick == 10'd959) begin
            r_st  <= S_RSP;
            r_vld <= 1'b1;
          end
        S_BIT_LOW:
          if (w_last && r_tick == w_lend) begin
            r_oe <= '0;
            r_st <= w_wbit ? S_BIT_WAIT : S_BIT_REC;
          end
        S_BIT_WAIT:
          if (w_smp) r_st <= S_BIT_REC;
        S_BIT_REC:
          if (w_last && r_tick == 10'd64) begin
            if (r_cmd == 2'b10 && r_bit != 3'd7) begin
              r_bit  <= r_bit + 3'd1;
              r_tick <= '0;
              r_oe   <= f_mask(r_chn);
              r_st   <= S_BIT_LOW;
            end else begin
              r_st  <= S_RSP;
              r_vld <= 1'b1;
            end
          end
        S_RSP:
          if (rsp_rdy) begin
            r_vld <= 1'b0;
            r_rdy <= 1'b1;
            r_st  <= S_IDLE;
          end
        default: r_st <= S_IDLE;
      endcase
      // Write-0 slots sample while still in the low phase.
      if (w_smp && (r_st == S_BIT_LOW || r_st == S_BIT_WAIT))
        r_rsp[r_bit] <= w_line;
    end
  end

  assign req_rdy = r_rdy;
  assign rsp_vld = r_vld;
  assign rsp_dat = r_rsp;
  assign rsp_prs = r_prs;
  assign owr_oe  = r_oe;

endmodule
